// File: rtl/fpu_arbiter.sv
// ============================================================================
// fpu_arbiter: round-robin arbiter sharing one FPU between two requesters,
// with done-level handshake, WAIT timeout (qNaN + err) and registered outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  output logic        ack0,
  output logic        ack1,
  output logic        rdy0,
  output logic        rdy1,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic [31:0] fpu_r,
  input  logic        fpu_done,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Counter only needs to reach TIMEOUT-1: the last WAIT cycle ends the wait.
  localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]     QNAN     = 32'h7FC0_0000;

  logic [1:0]       state;
  logic             ptr;
  logic             owner;
  logic [CNT_W-1:0] wait_cnt;

  logic        any_req;
  logic        win;
  logic        wait_end;
  logic [31:0] result;

  always_comb begin
    any_req = req0 | req1;
    win     = 1'b0;
    if (req0 && req1) begin
      win = ptr;
    end else if (req1) begin
      win = 1'b1;
    end
    wait_end = fpu_done || (wait_cnt == CNT_LAST);
    result   = fpu_done ? fpu_r : QNAN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      wait_cnt  <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdy0      <= 1'b0;
      rdy1      <= 1'b0;
      r0        <= '0;
      r1        <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= '0;
      fpu_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdy0 <= 1'b0;
      rdy1 <= 1'b0;
      case (state)
        IDLE: begin
          // A still-high fpu_done belongs to the previous op; let it drain first.
          if (any_req && !fpu_done) begin
            owner     <= win;
            fpu_a     <= win ? a1 : a0;
            fpu_b     <= win ? b1 : b0;
            fpu_op    <= win ? op1 : op0;
            ack0      <= ~win;
            ack1      <= win;
            fpu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_end) begin
            if (owner) begin
              r1   <= result;
              err1 <= ~fpu_done;
              rdy1 <= 1'b1;
            end else begin
              r0   <= result;
              err0 <= ~fpu_done;
              rdy0 <= 1'b1;
            end
            fpu_start <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          ptr   <= ~ptr;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          fpu_start <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
// ============================================================================
// tb_fpu_arbiter: directed, table-driven bench for fpu_arbiter with an FPU model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic        ack0, ack1, rdy0, rdy1, err0, err1;
  logic [31:0] r0, r1, fpu_a, fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_start, busy;
  logic [31:0] fpu_r;
  logic        fpu_done;

  fpu_arbiter #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1),
    .ack0(ack0), .ack1(ack1), .rdy0(rdy0), .rdy1(rdy1),
    .r0(r0), .r1(r1), .err0(err0), .err1(err1),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
    .fpu_r(fpu_r), .fpu_done(fpu_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FPU model: done after lat_m start cycles, optional extra hold after start falls.
  int mcnt = 0, hold = 0;
  int lat_m = 1, hold_len = 0;
  bit never_m = 1'b0;
  logic raw_done;
  assign raw_done = fpu_start && !never_m && (mcnt >= lat_m);
  assign fpu_done = raw_done || (hold > 0);
  assign fpu_r = (fpu_op == 2'd0) ? fpu_a + fpu_b :
                 (fpu_op == 2'd1) ? fpu_a - fpu_b :
                 (fpu_op == 2'd2) ? fpu_a ^ fpu_b : fpu_b;
  always @(posedge clk) begin
    mcnt <= fpu_start ? mcnt + 1 : 0;
    if (raw_done) hold <= hold_len;
    else if (hold > 0) hold <= hold - 1;
  end

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_r [2];
  bit exp_err [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0: return ack0;
      1: return ack1;
      2: return rdy0;
      default: return rdy1;
    endcase
  endfunction

  // Returns cycle stamp of the first negedge where the selected pulse is seen, or -1.
  task automatic wait_pulse(input int sel, input int bound, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (pick(sel)) begin
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, "_r0"}, r0, exp_r[0]);
    check({tag, "_r1"}, r1, exp_r[1]);
    check({tag, "_err"}, 32'({err1, err0}), 32'({exp_err[1], exp_err[0]}));
  endtask

  typedef struct {
    bit          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    int          lat;
    bit          never;
    logic [31:0] res;
    bit          err;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input int k);
    int n, got;
    bit other_rdy;
    string tag;
    tag = $sformatf("vec%0d", k);
    lat_m = v.lat;
    never_m = v.never;
    @(negedge clk);
    if (v.idx) begin req1 = 1'b1; a1 = v.a; b1 = v.b; op1 = v.op; end
    else       begin req0 = 1'b1; a0 = v.a; b0 = v.b; op0 = v.op; end
    n = cyc + 1;
    @(negedge clk);
    check({tag, "_ack"}, 32'({ack1, ack0}), v.idx ? 32'd2 : 32'd1);
    check({tag, "_fpu_a"}, fpu_a, v.a);
    check({tag, "_fpu_b"}, fpu_b, v.b);
    check({tag, "_fpu_op_start_busy"}, 32'({fpu_op, fpu_start, busy}), 32'({v.op, 2'b11}));
    req0 = 1'b0; req1 = 1'b0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    op0 = 2'($urandom); op1 = 2'($urandom);
    got = -1;
    other_rdy = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (v.idx ? rdy0 : rdy1) other_rdy = 1'b1;
      if (v.idx ? rdy1 : rdy0) begin
        got = cyc;
        break;
      end
    end
    check({tag, "_rdy_latency"}, 32'(got - n), 32'(v.lat + 1));
    check({tag, "_other_rdy"}, 32'(other_rdy), 32'd0);
    exp_r[v.idx] = v.res;
    exp_err[v.idx] = v.err;
    check_results(tag);
    @(negedge clk);
    check({tag, "_idle_after_resp"}, 32'({rdy1, rdy0, busy}), 32'd0);
  endtask

  int e, f, t;
  bit seen;

  initial begin
    vecs[0] = '{1'b0, 32'h3FA66666, 32'hBFB33333, 2'd0, 20,  1'b0, 32'hFF599999, 1'b0};
    vecs[1] = '{1'b1, 32'h00000010, 32'h00000003, 2'd1, 1,   1'b0, 32'h0000000D, 1'b0};
    vecs[2] = '{1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 2'd2, 5,   1'b0, 32'h0FF00FF0, 1'b0};
    vecs[3] = '{1'b1, 32'h12345678, 32'hCAFEBABE, 2'd3, 3,   1'b0, 32'hCAFEBABE, 1'b0};
    vecs[4] = '{1'b1, 32'h11111111, 32'h22222222, 2'd0, 255, 1'b1, 32'h7FC00000, 1'b1};
    vecs[5] = '{1'b0, 32'h00000001, 32'h00000002, 2'd0, 2,   1'b0, 32'h00000003, 1'b0};
    exp_r[0] = '0; exp_r[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b0;
    #1;
    check("reset_pulses", 32'({ack0, ack1, rdy0, rdy1}), 32'd0);
    check("reset_start_busy", 32'({fpu_start, busy}), 32'd0);
    check("reset_fpu_a", fpu_a, 32'd0);
    check("reset_fpu_b_op", fpu_b | 32'(fpu_op), 32'd0);
    check_results("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Done drain: fpu_done lingers 3 cycles after start falls, req1 pending.
    lat_m = 4; never_m = 1'b0; hold_len = 3;
    @(negedge clk);
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = 2'd0;
    @(negedge clk);
    check("drain_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    req1 = 1'b1; a1 = 32'd9; b1 = 32'd4; op1 = 2'd1;
    wait_pulse(2, 50, e);
    wait_pulse(1, 50, f);
    check("drain_ack1_delay", 32'(f - e), 32'd4);
    req1 = 1'b0;
    hold_len = 0;
    wait_pulse(3, 50, t);
    check("drain_rdy1_seen", 32'(t >= 0), 32'd1);
    exp_r[0] = 32'd8; exp_r[1] = 32'd5; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    check_results("drain");

    // Reset in mid-WAIT: outputs clear asynchronously, no rdy afterwards.
    never_m = 1'b1;
    @(negedge clk);
    req0 = 1'b1; a0 = 32'hDEAD0000; b0 = 32'h0000BEEF; op0 = 2'd2;
    @(negedge clk);
    req0 = 1'b0;
    repeat (10) @(negedge clk);
    check("midwait_busy_before", 32'({fpu_start, busy}), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("midwait_async_clear", 32'({fpu_start, busy}), 32'd0);
    exp_r[0] = '0; exp_r[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    check_results("midwait");
    never_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy0 || rdy1 || busy) seen = 1'b1;
    end
    check("midwait_no_rdy", 32'(seen), 32'd0);

    // Contention from reset: pointer 0 wins, then pointer flips to 1.
    lat_m = 2;
    @(negedge clk);
    req0 = 1'b1; a0 = 32'h00000100; b0 = 32'h00000020; op0 = 2'd0;
    req1 = 1'b1; a1 = 32'hAAAA0000; b1 = 32'h0000BBBB; op1 = 2'd2;
    @(negedge clk);
    check("cont_first_ack", 32'({ack1, ack0}), 32'd1);
    check("cont_first_fpu_a", fpu_a, 32'h00000100);
    req0 = 1'b0;
    wait_pulse(2, 50, t);
    exp_r[0] = 32'h00000120;
    check_results("cont_first");
    req0 = 1'b1; a0 = 32'h00000050; b0 = 32'h00000008; op0 = 2'd1;
    wait_pulse(1, 20, t);
    check("cont_second_ack1", 32'({ack1, ack0}), 32'd2);
    check("cont_second_fpu_a", fpu_a, 32'hAAAA0000);
    req1 = 1'b0;
    wait_pulse(3, 50, t);
    exp_r[1] = 32'hAAAABBBB;
    check_results("cont_second");
    wait_pulse(0, 20, t);
    check("cont_third_ack0", 32'(t >= 0), 32'd1);
    req0 = 1'b0;
    wait_pulse(2, 50, t);
    exp_r[0] = 32'h00000048;
    check_results("cont_third");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
